// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the memory stage, the DMA engine, the arbiter and the data memory.
// The slave modport is the arbiter's view. The master modport is the surrounding requesters and memory.
interface dmem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          p_req;
    logic          p_we;
    logic [AW-1:0] p_addr;
    logic [DW-1:0] p_wdata;
    logic [DW-1:0] p_rdata;
    logic          p_stall;

    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_last;
    logic          d_gnt;
    logic [DW-1:0] d_rdata;
    logic          d_rvalid;

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  p_req, p_we, p_addr, p_wdata,
        output p_rdata, p_stall,
        input  d_req, d_we, d_addr, d_wdata, d_last,
        output d_gnt, d_rdata, d_rvalid,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p_req, p_we, p_addr, p_wdata,
        input  p_rdata, p_stall,
        output d_req, d_we, d_addr, d_wdata, d_last,
        input  d_gnt, d_rdata, d_rvalid,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter. The pipeline has default priority.
// DMA wins after MAX_WAIT denied cycles and may then hold the memory for bursts of up to MAX_BURST beats.
module dmem_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_WAIT  = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);
    localparam int WW = (MAX_WAIT  > 1) ? $clog2(MAX_WAIT + 1)  : 1;
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST + 1) : 1;
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state_reg, state_next;
    logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
    logic [BW-1:0] beat_cnt_reg, beat_cnt_next;
    logic [DW-1:0] d_rdata_reg, d_rdata_next;
    logic          d_rvalid_reg, d_rvalid_next;

    logic          dma_win;
    logic [AW-1:0] addr_sel;

    // Once a burst is open, the pipeline cannot pre-empt it.
    // Only d_req dropping, d_last, or the beat limit ends the burst.
    assign dma_win  = bus.d_req && ((state_reg == BURST) || !bus.p_req || (wait_cnt_reg == WAIT_MAX));
    assign addr_sel = dma_win ? bus.d_addr : bus.p_addr;

    assign bus.mem_addr  = addr_sel;
    assign bus.mem_wdata = dma_win ? bus.d_wdata : bus.p_wdata;
    assign bus.mem_we    = rst && (dma_win ? bus.d_we : (bus.p_req && bus.p_we));
    assign bus.d_gnt     = rst && dma_win;
    assign bus.p_stall   = dma_win && bus.p_req;
    assign bus.p_rdata   = bus.mem_rdata;
    assign bus.d_rdata   = d_rdata_reg;
    assign bus.d_rvalid  = d_rvalid_reg;

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        beat_cnt_next = beat_cnt_reg;
        d_rdata_next  = d_rdata_reg;
        d_rvalid_next = dma_win && !bus.d_we;

        if (dma_win && !bus.d_we) begin
            d_rdata_next = bus.mem_rdata;
        end

        if (dma_win) begin
            wait_cnt_next = '0;
            if (state_reg == IDLE) begin
                if (!bus.d_last && (MAX_BURST > 1)) begin
                    state_next    = BURST;
                    beat_cnt_next = BW'(1);
                end
            end else if ((beat_cnt_reg + BW'(1) == BURST_MAX) || bus.d_last) begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end else begin
                beat_cnt_next = beat_cnt_reg + BW'(1);
            end
        end else begin
            if (bus.d_req && (wait_cnt_reg != WAIT_MAX)) begin
                wait_cnt_next = wait_cnt_reg + WW'(1);
            end
            // In BURST, losing can only mean d_req dropped: close the burst.
            state_next    = IDLE;
            beat_cnt_next = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            beat_cnt_reg <= '0;
            d_rdata_reg  <= '0;
            d_rvalid_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            beat_cnt_reg <= beat_cnt_next;
            d_rdata_reg  <= d_rdata_next;
            d_rvalid_reg <= d_rvalid_next;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed plus randomized bench for dmem_arbiter.
// A cycle-level reference model predicts every output from the arbitration rules.
module tb_dmem_arbiter;
    localparam int MAX_WAIT  = 8;
    localparam int MAX_BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

    dmem_arbiter #(.AW(32), .DW(32), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Physical memory seen by the DUT. Addresses are kept below 0x400.
    logic [31:0] tmem [0:255];
    assign bus.mem_rdata = tmem[bus.mem_addr[9:2]];
    always @(posedge clk) if (bus.mem_we) tmem[bus.mem_addr[9:2]] <= bus.mem_wdata;

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          m_wait;
    int          m_beats;     // beats taken in the current DMA ownership, 0 = none open
    logic        m_rvalid;
    logic [31:0] m_rdata;

    int n_pass   = 0;
    int n_checks = 0;

    logic        obs_stall, obs_gnt, obs_rvalid;
    logic [31:0] obs_prdata, obs_drdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic cyc(input logic preq, input logic pwe, input logic [31:0] paddr, input logic [31:0] pwdata,
                       input logic dreq, input logic dwe, input logic [31:0] daddr, input logic [31:0] dwdata,
                       input logic dlast, input logic rst_v);
        logic        win, gnt, we;
        logic [31:0] addr, rd;
        @(negedge clk);
        rst         = rst_v;
        bus.p_req   = preq;  bus.p_we = pwe;  bus.p_addr = paddr;  bus.p_wdata = pwdata;
        bus.d_req   = dreq;  bus.d_we = dwe;  bus.d_addr = daddr;  bus.d_wdata = dwdata;
        bus.d_last  = dlast;
        if (!rst_v) begin
            m_wait = 0; m_beats = 0; m_rvalid = 1'b0; m_rdata = 32'h0;
        end
        #1;
        win  = dreq && (m_beats > 0 || !preq || m_wait >= MAX_WAIT);
        gnt  = win && rst_v;
        we   = rst_v && (win ? dwe : (preq && pwe));
        addr = win ? daddr : paddr;
        rd   = ref_mem[addr[9:2]];

        obs_stall  = bus.p_stall;
        obs_gnt    = bus.d_gnt;
        obs_rvalid = bus.d_rvalid;
        obs_prdata = bus.p_rdata;
        obs_drdata = bus.d_rdata;

        chk("p_stall",  32'(bus.p_stall),  32'(win && preq));
        chk("d_gnt",    32'(bus.d_gnt),    32'(gnt));
        chk("mem_we",   32'(bus.mem_we),   32'(we));
        chk("mem_addr", bus.mem_addr,      addr);
        chk("p_rdata",  bus.p_rdata,       rd);
        chk("d_rvalid", 32'(bus.d_rvalid), 32'(m_rvalid));
        chk("d_rdata",  bus.d_rdata,       m_rdata);
        if (we) chk("mem_wdata", bus.mem_wdata, win ? dwdata : pwdata);

        @(posedge clk);
        if (rst_v) begin
            if (we) ref_mem[addr[9:2]] = win ? dwdata : pwdata;
            m_rvalid = gnt && !dwe;
            if (m_rvalid) m_rdata = rd;
            if (gnt) begin
                m_wait = 0;
                m_beats++;
                if (m_beats >= MAX_BURST || dlast) m_beats = 0;
            end else begin
                if (dreq && m_wait < MAX_WAIT) m_wait++;
                m_beats = 0;
            end
        end
    endtask

    logic        rp_req, rp_we, rd_req, rd_we, rd_last, r_rst;
    logic [31:0] rp_addr, rp_wdata, rd_addr, rd_wdata;

    initial begin
        for (int i = 0; i < 256; i++) begin
            tmem[i]    = 32'h0;
            ref_mem[i] = 32'h0;
        end
        m_wait = 0; m_beats = 0; m_rvalid = 1'b0; m_rdata = 32'h0;
        bus.p_req = 0; bus.p_we = 0; bus.p_addr = 0; bus.p_wdata = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0; bus.d_last = 0;

        // Reset held with both requesters active, then the first served cycle
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 32'h20, 0, 1, 1, 32'h30, 32'h55, 0, 0);
            chk("t1_rst_gnt",   32'(obs_gnt),    32'h0);
            chk("t1_rst_stall", 32'(obs_stall),  32'h0);
            chk("t1_rst_rv",    32'(obs_rvalid), 32'h0);
        end
        cyc(1, 0, 32'h20, 0, 1, 1, 32'h30, 32'h55, 0, 1);
        chk("t1_first_stall", 32'(obs_stall), 32'h0);
        chk("t1_first_gnt",   32'(obs_gnt),   32'h0);

        // Pipeline store then load
        cyc(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 32'h10, 0,            0, 0, 0, 0, 0, 1);
        chk("t2_load", obs_prdata, 32'hDEADBEEF);

        // Four-beat DMA write burst, then pipeline reads beat 3
        for (int b = 0; b < 4; b++) begin
            cyc(0, 0, 0, 0, 1, 1, 32'h100 + 32'(4 * b), 32'hA0 + 32'(b), (b == 3), 1);
            chk("t3_gnt", 32'(obs_gnt), 32'h1);
        end
        cyc(1, 0, 32'h108, 0, 0, 0, 0, 0, 0, 1);
        chk("t3_load", obs_prdata, 32'hA2);

        // Starvation: DMA forced in on the ninth contended cycle
        for (int i = 0; i < 9; i++) begin
            cyc(1, 0, 32'h20, 0, 1, 0, 32'h40, 0, 1, 1);
            chk("t4_gnt",   32'(obs_gnt),   32'(i == 8));
            chk("t4_stall", 32'(obs_stall), 32'(i == 8));
        end

        // Forced win with d_last never set: four beats, then release
        for (int i = 0; i < 13; i++) begin
            cyc(1, 0, 32'h24, 0, 1, 1, 32'h200 + 32'(4 * i), 32'(i), 0, 1);
            chk("t5_gnt",   32'(obs_gnt),   32'(i >= 8 && i < 12));
            chk("t5_stall", 32'(obs_stall), 32'(i >= 8 && i < 12));
        end

        // DMA read latency, then reset during a burst
        cyc(0, 0, 0, 0, 1, 0, 32'h10, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_rvalid", 32'(obs_rvalid), 32'h1);
        chk("t6_rdata",  obs_drdata,      32'hDEADBEEF);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t6_rvalid_pulse", 32'(obs_rvalid), 32'h0);
        cyc(0, 0, 0, 0, 1, 1, 32'h300, 32'h1, 0, 1);
        cyc(0, 0, 0, 0, 1, 1, 32'h304, 32'h2, 0, 1);
        cyc(1, 0, 32'h20, 0, 1, 1, 32'h308, 32'h3, 0, 0);
        chk("t6_abort_gnt", 32'(obs_gnt), 32'h0);
        cyc(1, 0, 32'h20, 0, 1, 1, 32'h308, 32'h3, 0, 1);
        chk("t6_idle_gnt",   32'(obs_gnt),   32'h0);
        chk("t6_idle_stall", 32'(obs_stall), 32'h0);

        // Randomized traffic; a stalled pipeline request is held unchanged
        rp_req = 0; rp_we = 0; rp_addr = 0; rp_wdata = 0;
        for (int i = 0; i < 400; i++) begin
            if (!obs_stall) begin
                rp_req   = ($urandom_range(0, 3) != 0);
                rp_we    = $urandom_range(0, 1);
                rp_addr  = 32'($urandom_range(0, 255)) << 2;
                rp_wdata = $urandom;
            end
            rd_req   = ($urandom_range(0, 2) != 0);
            rd_we    = $urandom_range(0, 1);
            rd_addr  = 32'($urandom_range(0, 255)) << 2;
            rd_wdata = $urandom;
            rd_last  = ($urandom_range(0, 3) == 0);
            r_rst    = ($urandom_range(0, 63) != 0);
            cyc(rp_req, rp_we, rp_addr, rp_wdata, rd_req, rd_we, rd_addr, rd_wdata, rd_last, r_rst);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
